// File: rtl/physics_integrator.sv
// physics_integrator: per-frame fixed-point position/velocity integrator with
// ground/air/hitstun tracking, multi-jump, platform drop-through and knockback decay.
module physics_integrator #(
    parameter int FRAC = 16,
    parameter int INT_W = 16,
    parameter int MAX_JUMPS = 2,
    parameter int JUMP_V = 4,
    parameter int VMAX = 8,
    parameter int HITSTUN_FRAMES = 30,
    parameter int DEADZONE = 16,
    localparam int W = INT_W + FRAC
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         frame_tick,
    input  logic         freeze_in,
    input  logic [31:0]  start_position,
    input  logic [W-1:0] inv_mass,
    input  logic [W-1:0] gravity,
    input  logic [31:0]  controller_in,
    input  logic [31:0]  knockback_in,
    input  logic         attack_in,
    input  logic [4:0]   wall,
    output logic [31:0]  position,
    output logic [1:0]   state,
    output logic [1:0]   jumps_used
);
    localparam int PW = 2 * W;
    localparam int CW = $clog2(HITSTUN_FRAMES + 1);
    localparam logic signed [W-1:0] VLIM = W'(VMAX) << FRAC;
    localparam logic signed [W-1:0] JVEL = W'(JUMP_V) << FRAC;
    localparam logic signed [8:0] DZ = 9'(DEADZONE);

    typedef enum logic [1:0] {GROUND = 2'd0, AIR = 2'd1, HITSTUN = 2'd2} state_t;

    state_t st, st_n;
    logic signed [W-1:0] pos_x, pos_y, vel_x, vel_y, vx_n, vy_n, drive_x, kb_vx, kb_vy;
    logic signed [8:0] sx_raw, sx;
    logic [1:0] ju_n;
    logic [CW-1:0] cnt, cnt_n;
    logic tick, jump_req, down, jump_edge, attack_edge, contact;
    logic jump_prev, attack_prev, drop_mask, dm_n;
    logic unused_ctrl;

    assign unused_ctrl = ^controller_in[31:16];
    assign tick = frame_tick & ~freeze_in;
    assign sx_raw = $signed({1'b0, controller_in[15:8]}) - 9'sd128;
    assign sx = (sx_raw > -DZ && sx_raw < DZ) ? '0 : sx_raw;
    assign jump_req = controller_in[7:0] >= 8'd240;
    assign down = controller_in[7:0] < 8'd16;
    assign jump_edge = jump_req & ~jump_prev;
    assign attack_edge = attack_in & ~attack_prev;
    assign contact = wall[1] | (wall[4] & ~drop_mask);

    // Products are formed at double width and truncated, so mass never needs a divider
    assign drive_x = W'((PW'(sx) * PW'($signed({1'b0, inv_mass}))) >>> 7);
    assign kb_vx = W'(PW'($signed(knockback_in[31:16])) * PW'($signed({1'b0, inv_mass})));
    assign kb_vy = W'(PW'($signed(knockback_in[15:0])) * PW'($signed({1'b0, inv_mass})));

    always_comb begin
        st_n = st;
        vx_n = vel_x;
        vy_n = vel_y;
        ju_n = jumps_used;
        cnt_n = cnt;
        dm_n = drop_mask;
        if (attack_edge) begin
            vx_n = kb_vx;
            vy_n = kb_vy;
            cnt_n = CW'(HITSTUN_FRAMES);
            st_n = HITSTUN;
        end else if (st == GROUND) begin
            vx_n = drive_x;
            vy_n = '0;
            ju_n = '0;
            if (jump_edge) begin
                vy_n = JVEL;
                ju_n = 2'd1;
                st_n = AIR;
            end else if (down && wall[4] && !wall[1]) begin
                dm_n = 1'b1;
                st_n = AIR;
            end else if (!wall[1] && (!wall[4] || drop_mask)) begin
                st_n = AIR;
            end
        end else if (st == AIR) begin
            vx_n = drive_x;
            vy_n = vel_y - $signed(gravity);
            if (jump_edge && 32'(jumps_used) < MAX_JUMPS) begin
                vy_n = JVEL;
                ju_n = jumps_used + 2'd1;
            end
            if (contact && (vy_n[W-1] || vy_n == '0)) begin
                vy_n = '0;
                ju_n = '0;
                st_n = GROUND;
            end
            if (!wall[4])
                dm_n = 1'b0;
        end else begin
            vx_n = vel_x - (vel_x >>> 3);
            vy_n = vel_y - (vel_y >>> 3) - $signed(gravity);
            cnt_n = cnt - CW'(1);
            if (cnt_n == '0 && contact) begin
                vy_n = '0;
                ju_n = '0;
                st_n = GROUND;
            end else if (cnt_n == '0) begin
                st_n = AIR;
            end
        end
        // Wall contact only blocks motion into the wall, then both axes saturate
        if ((wall[3] && (wall[2] || vx_n[W-1])) || (wall[2] && !vx_n[W-1] && vx_n != '0))
            vx_n = '0;
        if (wall[0] && !vy_n[W-1] && vy_n != '0)
            vy_n = '0;
        vx_n = vx_n > VLIM ? VLIM : (vx_n < -VLIM ? -VLIM : vx_n);
        vy_n = vy_n > VLIM ? VLIM : (vy_n < -VLIM ? -VLIM : vy_n);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pos_x <= W'(start_position[31:16]) << FRAC;
            pos_y <= W'(start_position[15:0]) << FRAC;
            vel_x <= '0;
            vel_y <= '0;
            st <= AIR;
            jumps_used <= '0;
            cnt <= '0;
            jump_prev <= 1'b0;
            attack_prev <= 1'b0;
            drop_mask <= 1'b0;
        end else if (tick) begin
            pos_x <= pos_x + vel_x;
            pos_y <= pos_y + vel_y;
            vel_x <= vx_n;
            vel_y <= vy_n;
            st <= st_n;
            jumps_used <= ju_n;
            cnt <= cnt_n;
            jump_prev <= jump_req;
            attack_prev <= attack_in;
            drop_mask <= dm_n;
        end
    end

    assign position = {16'(pos_x[W-1:FRAC]), 16'(pos_y[W-1:FRAC])};
    assign state = st;
endmodule

// File: tb/tb_physics_integrator.sv
// tb_physics_integrator: directed and randomized checks of physics_integrator
// against a behavioural per-frame motion model.
module tb_physics_integrator;
    logic clock = 1'b0;
    logic reset, frame_tick, freeze_in, attack_in;
    logic [31:0] start_position, inv_mass, gravity, controller_in, knockback_in, position;
    logic [4:0] wall;
    logic [1:0] state, jumps_used;
    int checks = 0;
    int errors = 0;
    int mpx, mpy, mvx, mvy, mst, mju, mcnt;
    bit mjp, map, mdm;

    physics_integrator dut (
        .clock(clock),
        .reset(reset),
        .frame_tick(frame_tick),
        .freeze_in(freeze_in),
        .start_position(start_position),
        .inv_mass(inv_mass),
        .gravity(gravity),
        .controller_in(controller_in),
        .knockback_in(knockback_in),
        .attack_in(attack_in),
        .wall(wall),
        .position(position),
        .state(state),
        .jumps_used(jumps_used)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        mpx = int'({start_position[31:16], 16'h0000});
        mpy = int'({start_position[15:0], 16'h0000});
        mvx = 0;
        mvy = 0;
        mst = 1;
        mju = 0;
        mcnt = 0;
        mjp = 0;
        map = 0;
        mdm = 0;
    endtask

    // One frame of the game rules, in plain integer arithmetic (Q16.16 in int)
    task automatic m_tick();
        int sx, nvx, nvy;
        bit jr, je, ae, land;
        sx = int'(controller_in[15:8]) - 128;
        if (sx > -16 && sx < 16) sx = 0;
        jr = controller_in[7:0] >= 8'd240;
        je = jr && !mjp;
        ae = attack_in && !map;
        land = wall[1] || (wall[4] && !mdm);
        nvx = int'((longint'(sx) * longint'(inv_mass)) >>> 7);
        if (ae) begin
            nvx = int'(longint'($signed(knockback_in[31:16])) * longint'(inv_mass));
            nvy = int'(longint'($signed(knockback_in[15:0])) * longint'(inv_mass));
            mcnt = 30;
            mst = 2;
        end else if (mst == 0) begin
            nvy = 0;
            mju = 0;
            if (je) begin
                nvy = 4 * 65536;
                mju = 1;
                mst = 1;
            end else if (controller_in[7:0] < 8'd16 && wall[4] && !wall[1]) begin
                mdm = 1;
                mst = 1;
            end else if (!wall[1] && (!wall[4] || mdm)) begin
                mst = 1;
            end
        end else if (mst == 1) begin
            nvy = mvy - int'(gravity);
            if (je && mju < 2) begin
                nvy = 4 * 65536;
                mju++;
            end
            if (land && nvy <= 0) begin
                nvy = 0;
                mju = 0;
                mst = 0;
            end
            if (!wall[4]) mdm = 0;
        end else begin
            nvx = mvx - (mvx >>> 3);
            nvy = mvy - (mvy >>> 3) - int'(gravity);
            mcnt--;
            if (mcnt == 0) begin
                if (land) begin
                    mst = 0;
                    nvy = 0;
                    mju = 0;
                end else mst = 1;
            end
        end
        if (wall[3] && nvx < 0) nvx = 0;
        if (wall[2] && nvx > 0) nvx = 0;
        if (wall[0] && nvy > 0) nvy = 0;
        if (nvx > 8 * 65536) nvx = 8 * 65536;
        if (nvx < -8 * 65536) nvx = -8 * 65536;
        if (nvy > 8 * 65536) nvy = 8 * 65536;
        if (nvy < -8 * 65536) nvy = -8 * 65536;
        mpx += mvx;
        mpy += mvy;
        mvx = nvx;
        mvy = nvy;
        mjp = jr;
        map = attack_in;
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) m_reset();
        else if (frame_tick && !freeze_in) m_tick();
        #1;
        check("position", position, {mpx[31:16], mpy[31:16]});
        check("state", state, mst);
        check("jumps_used", jumps_used, mju);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    function automatic logic [7:0] pick8();
        logic [7:0] v [11] = '{8'd0, 8'd15, 8'd16, 8'd112, 8'd113, 8'd128, 8'd143, 8'd144, 8'd239, 8'd240, 8'd255};
        if ($urandom_range(0, 11) == 11) return 8'($urandom);
        return v[$urandom_range(0, 10)];
    endfunction

    initial begin
        logic [31:0] snap;
        int px0;
        reset = 1;
        frame_tick = 0;
        freeze_in = 0;
        attack_in = 0;
        start_position = 32'h0064_0032;
        inv_mass = 32'h0001_0000;
        gravity = 0;
        controller_in = 32'h8080;
        knockback_in = 0;
        wall = 0;
        run(2);
        reset = 0;
        run(5);
        check("reset_pos", position, 32'h0064_0032);
        check("reset_state", state, 1);

        gravity = 32'h1000;
        frame_tick = 1;
        run(16);
        check("fall_y", position[15:0], 42);

        wall = 5'h02;
        run(1);
        check("land_state", state, 0);
        controller_in = 32'h80FF;
        run(1);
        check("jump1_state", state, 1);
        check("jump1_count", jumps_used, 1);
        run(1);
        check("jump_hold", jumps_used, 1);
        controller_in = 32'h8080;
        run(1);
        controller_in = 32'h80FF;
        run(1);
        check("jump2_count", jumps_used, 2);
        controller_in = 32'h8080;
        run(1);
        controller_in = 32'h80FF;
        run(1);
        check("jump3_ignored", jumps_used, 2);

        controller_in = 32'h8080;
        wall = 0;
        inv_mass = 32'h8000;
        knockback_in = 32'h0010_0008;
        attack_in = 1;
        run(1);
        check("hit_state", state, 2);
        px0 = int'(position[31:16]);
        run(1);
        check("kb_dx_8", int'(position[31:16]) - px0, 8);
        run(1);
        check("kb_dx_15", int'(position[31:16]) - px0, 15);
        controller_in = 32'hFFFF;
        run(27);
        check("hitstun_hold", state, 2);
        run(1);
        check("hitstun_exit", state, 1);

        controller_in = 32'h8080;
        attack_in = 0;
        run(1);
        attack_in = 1;
        run(1);
        check("hit2_state", state, 2);
        run(5);
        snap = position;
        freeze_in = 1;
        run(10);
        check("freeze_pos", position, snap);
        check("freeze_state", state, 2);
        freeze_in = 0;
        run(24);
        check("freeze_cnt_held", state, 2);
        run(1);
        check("freeze_exit", state, 1);

        attack_in = 0;
        run(1);
        attack_in = 1;
        run(3);
        check("hit3_state", state, 2);
        reset = 1;
        run(1);
        reset = 0;
        check("reset_mid_pos", position, 32'h0064_0032);
        check("reset_mid_state", state, 1);

        attack_in = 0;
        gravity = 0;
        controller_in = 32'hFF80;
        inv_mass = 32'h8000;
        run(3);
        wall = 5'h04;
        run(1);
        snap = position;
        run(2);
        check("wall_right_stop", position, snap);
        wall = 5'h08;
        run(4);
        check("wall_left_free", position[31:16] > snap[31:16], 1);

        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(0, 199) == 0;
            frame_tick = $urandom_range(0, 9) < 7;
            freeze_in = $urandom_range(0, 9) == 0;
            if ($urandom_range(0, 15) == 0) attack_in = ~attack_in;
            if ($urandom_range(0, 3) == 0) controller_in = {16'($urandom), pick8(), pick8()};
            if ($urandom_range(0, 7) == 0) wall = 5'($urandom);
            if ($urandom_range(0, 31) == 0) inv_mass = $urandom_range(0, 32'h30000);
            if ($urandom_range(0, 31) == 0) gravity = $urandom_range(0, 32'h4000);
            if ($urandom_range(0, 15) == 0)
                knockback_in = {16'($urandom_range(0, 80) - 40), 16'($urandom_range(0, 80) - 40)};
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
